// File: rtl/xsw_pkg.sv
// Shared switch definitions: arbitration mode and the index-width helper
// used wherever a port index has to be carried.
package xsw_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } mode_e;

  // Index width for n ports, never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xrr_pick.sv
// Rotating-priority picker: returns the first set request at or after ptr,
// wrapping modulo N_IN. With no request, idx falls back to ptr.
module xrr_pick
  import xsw_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int PTR_W = ptr_w(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic             any,
  output logic [PTR_W-1:0] idx
);

  always_comb begin
    logic found;
    int   c;
    any   = |req;
    idx   = ptr;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N_IN; k++) begin
      c = (int'(ptr) + k) % N_IN;
      for (int i = 0; i < N_IN; i++) begin
        if (!found && (i == c) && req[i]) begin
          idx   = PTR_W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/xarb_rr_pkt.sv
// Packet-aware round-robin arbiter/mux feeding the output register slice.
// Grant is held from the first offered beat until the last beat transfers.
module xarb_rr_pkt
  import xsw_pkg::*;
#(
  parameter  int N_IN    = 4,
  parameter  int D_WIDTH = 16,
  localparam int PTR_W   = ptr_w(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN-1:0]         vld_s,
  output logic [N_IN-1:0]         rdy_s,
  input  logic [N_IN*D_WIDTH-1:0] data_s,
  input  logic [N_IN-1:0]         last_s,
  output logic                    vld_m,
  input  logic                    rdy_m,
  output logic [D_WIDTH-1:0]      data_m,
  output logic                    last_m,
  output logic [PTR_W-1:0]        gnt_idx
);

  // Handshake: a beat moves when valid and ready are both high on a rising
  // edge. A source holds valid/data/last until it sees ready; valid never
  // depends on ready, and ready is only raised toward the selected source
  // while the downstream is ready and the selection is presenting a beat.

  typedef struct packed {
    mode_e            mode;
    logic [PTR_W-1:0] cur;
    logic [PTR_W-1:0] ptr;
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             pick_any;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] sel;
  logic             cur_vld;
  logic             hs;

  xrr_pick #(
    .N_IN  (N_IN),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (vld_s),
    .ptr (state_q.ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign sel = (state_q.mode == LOCK) ? state_q.cur : pick_idx;

  always_comb begin
    cur_vld = 1'b0;
    data_m  = '0;
    last_m  = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (state_q.cur == PTR_W'(i)) cur_vld = vld_s[i];
      if (sel == PTR_W'(i)) begin
        data_m = data_s[i*D_WIDTH +: D_WIDTH];
        last_m = last_s[i];
      end
    end
  end

  // Outputs are gated by rst directly so nothing is offered during reset.
  assign vld_m   = !rst && ((state_q.mode == LOCK) ? cur_vld : pick_any);
  assign gnt_idx = sel;
  assign hs      = vld_m && rdy_m;

  always_comb begin
    rdy_s = '0;
    if (hs) rdy_s[sel] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (hs && last_m) begin
      state_d.mode = ARB;
      state_d.ptr  = (sel == PTR_W'(N_IN - 1)) ? '0 : sel + PTR_W'(1);
    end else if (vld_m) begin
      // Stalled or mid-packet beat: pin the selection until the last beat.
      state_d.mode = LOCK;
      state_d.cur  = sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q.mode <= ARB;
      state_q.cur  <= '0;
      state_q.ptr  <= '0;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_xarb_rr_pkt.sv
// Randomized bench for xarb_rr_pkt: packet-level round-robin reference model
// feeds an expected-beat queue that a separate monitor drains.
module tb_xarb_rr_pkt;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int PW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    vld_s;
  logic [N-1:0]    rdy_s;
  logic [N*DW-1:0] data_s;
  logic [N-1:0]    last_s;
  logic            vld_m;
  logic            rdy_m;
  logic [DW-1:0]   data_m;
  logic            last_m;
  logic [PW-1:0]   gnt_idx;

  always #5 clk = ~clk;

  xarb_rr_pkt #(.N_IN(N), .D_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .vld_s   (vld_s),
    .rdy_s   (rdy_s),
    .data_s  (data_s),
    .last_s  (last_s),
    .vld_m   (vld_m),
    .rdy_m   (rdy_m),
    .data_m  (data_m),
    .last_m  (last_m),
    .gnt_idx (gnt_idx)
  );

  logic [PW+DW:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Source state per input: the beat currently offered and packet progress.
  bit            pres[N];
  bit            acc[N];
  bit            cur_last[N];
  logic [DW-1:0] cur_data[N];
  int            left[N];

  // Reference model: owning input of the packet in flight (-1 = none) and
  // the round-robin start point.
  int            owner = -1;
  int            rr    = 0;
  bit            exp_vld;
  logic [N-1:0]  exp_rdy;

  task automatic step(input int p_vld, input int p_rdy, input int max_len,
                      input bit do_rst);
    int  sel;
    bit  v;
    rst = do_rst;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) pres[i] = 1'b0;
      acc[i] = 1'b0;
      if (!pres[i] && ($urandom_range(0, 99) < p_vld)) begin
        if (left[i] == 0) left[i] = $urandom_range(1, max_len);
        cur_data[i] = DW'($urandom);
        cur_last[i] = (left[i] == 1);
        left[i]     = left[i] - 1;
        pres[i]     = 1'b1;
      end
      vld_s[i]           = pres[i];
      last_s[i]          = cur_last[i];
      data_s[i*DW +: DW] = cur_data[i];
    end
    rdy_m = ($urandom_range(0, 99) < p_rdy);

    sel = 0;
    v   = 1'b0;
    if (do_rst) begin
      owner = -1;
      rr    = 0;
    end else if (owner >= 0) begin
      sel = owner;
      v   = pres[owner];
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (rr + k) % N;
        if (!v && pres[c]) begin
          v   = 1'b1;
          sel = c;
        end
      end
    end

    exp_vld = v;
    exp_rdy = '0;
    if (v) begin
      if (rdy_m) begin
        exp_rdy[sel] = 1'b1;
        exp_q.push_back({PW'(sel), cur_last[sel], cur_data[sel]});
        acc[sel] = 1'b1;
        if (cur_last[sel]) begin
          owner = -1;
          rr    = (sel + 1) % N;
        end else begin
          owner = sel;
        end
      end else begin
        owner = sel;
      end
    end
  endtask

  // Monitor: samples just after the falling edge, when inputs have settled.
  initial begin
    logic [PW+DW:0] e;
    forever begin
      @(negedge clk);
      #1;
      total++;
      if (vld_m !== exp_vld) begin
        bad++;
        $display("FAIL vld_m: got %b want %b at %0t", vld_m, exp_vld, $time);
      end
      total++;
      if (rdy_s !== exp_rdy) begin
        bad++;
        $display("FAIL rdy_s: got %b want %b at %0t", rdy_s, exp_rdy, $time);
      end
      if (vld_m === 1'b1 && rdy_m === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat: got unexpected %h want none at %0t",
                   {gnt_idx, last_m, data_m}, $time);
        end else begin
          e = exp_q.pop_front();
          if ({gnt_idx, last_m, data_m} !== e) begin
            bad++;
            $display("FAIL beat: got idx=%0d last=%b data=%h want idx=%0d last=%b data=%h at %0t",
                     gnt_idx, last_m, data_m, e[PW+DW:DW+1], e[DW], e[DW-1:0], $time);
          end
        end
      end
    end
  end

  initial begin
    bit did_rst;
    bit pulse;
    rst   = 1'b1;
    rdy_m = 1'b0;
    vld_s = '0; last_s = '0; data_s = '0;
    for (int i = 0; i < N; i++) begin
      pres[i] = 1'b0; acc[i] = 1'b0; cur_last[i] = 1'b0;
      cur_data[i] = '0; left[i] = 0;
    end

    // Reset with every input requesting, then single-beat fairness.
    step(100, 100, 1, 1'b1);
    @(negedge clk); step(100, 100, 1, 1'b1);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk); step(100, 100, 1, 1'b0);
    end

    // Mixed packets with gaps and backpressure; one reset inside a packet.
    did_rst = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      pulse = (c >= 150) && !did_rst && (owner >= 0);
      if (pulse) did_rst = 1'b1;
      step(70, 60, 4, pulse);
    end

    // Heavy backpressure to exercise held selections.
    for (int c = 0; c < 150; c++) begin
      @(negedge clk); step(80, 15, 3, 1'b0);
    end

    // Drain whatever is still being offered.
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); step(0, 100, 1, 1'b0);
    end

    @(negedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d beats outstanding want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xarb_rr_pkt.md
Name: xarb_rr_pkt

Overview:
N-input packet-aware round-robin arbiter/mux. It sits directly upstream of the switch's output register slice (XRs) and drives that slice's vld_s/data_s/rdy_s handshake. It selects one requesting input, forwards its beats combinationally, and holds the grant until the beat flagged last is transferred. Zero-latency datapath; registering is left to the downstream slice.

Parameters:
N_IN, 4, number of input ports (>=1)
D_WIDTH, 16, payload width per port (excluding last flag)
PTR_W, (N_IN>1 ? $clog2(N_IN) : 1), localparam, width of grant/pointer index

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  reset; one clock; reset is asynchronous and active-high
vld_s  input  N_IN  per-input valid
rdy_s  output  N_IN  per-input ready; at most one bit high
data_s  input  N_IN*D_WIDTH  packed payloads; port i at [i*D_WIDTH +: D_WIDTH]
last_s  input  N_IN  per-input last-beat-of-packet flag
vld_m  output  1  valid to downstream slice
rdy_m  input  1  ready from downstream slice
data_m  output  D_WIDTH  selected payload
last_m  output  1  selected last flag
gnt_idx  output  PTR_W  index of selected input (meaningful when vld_m=1)

Behaviour:
- State: mode {ARB, LOCK}, cur (PTR_W, locked input), ptr (PTR_W, highest-priority input for next arbitration).
- Reset (async, while rst=1 and after release): mode=ARB, ptr=0, cur=0; vld_m=0, all rdy_s=0 while rst=1 (outputs gated by rst, not only by state).
- ARB: sel = first i with vld_s[i]=1, searching ptr, ptr+1, ..., wrapping modulo N_IN. vld_m=|vld_s; data_m/last_m/gnt_idx from sel; rdy_s[sel]=rdy_m, others 0. No requester: vld_m=0, data_m don't-care (drive port sel=ptr), gnt_idx=ptr.
- LOCK: sel=cur unconditionally; vld_m=vld_s[cur]; rdy_s[cur]=rdy_m, others 0; other requesters ignored.
- Handshake hs = vld_m & rdy_m.
- Transitions, evaluated in both modes:
  - hs & last_m: mode<=ARB; ptr<=(sel+1) mod N_IN (wraps N_IN-1 -> 0).
  - vld_m & ~(hs & last_m), i.e. stalled beat or non-last beat: mode<=LOCK; cur<=sel. This keeps the selection stable across downstream backpressure.
  - ~vld_m: no change.
- Upstream rule: each input holds vld_s/data_s/last_s until accepted. Grant never changes while vld_m=1 without a last handshake.
- Single-beat packets (last_s=1) never hold LOCK past the accepting cycle; back-to-back single beats from different inputs give one beat per cycle with no bubble.
- Simultaneous: a new request arriving on the cycle a last beat completes participates in the next arbitration using the updated ptr.
- Locked input dropping vld mid-packet: stay LOCK, vld_m=0, wait; no timeout.
- N_IN=1: ptr/cur stay 0; block degenerates to pass-through with LOCK tracking.
- rst asserted mid-packet: immediate return to ARB/ptr=0; the partial packet is abandoned (upstream reset is the system's responsibility).

Decomposition:
- Shared package xsw_pkg: mode enum (ARB, LOCK) and the PTR_W computation function (clog2 with min 1), reused by the other switch blocks.
- One sub-module xrr_pick: combinational rotating-priority picker; inputs req[N_IN], ptr; outputs any, idx. Instantiated once in ARB path.

Test Plan:
- Reset: rst=1 with all vld_s=1 -> vld_m=0, rdy_s=0; release, rdy_m=1 -> first grant to input 0, ptr becomes 1.
- Fairness: N_IN=4, all inputs continuously valid, single-beat, rdy_m=1 -> gnt_idx sequence 0,1,2,3,0,1... one beat per cycle.
- Packet lock: input 2 sends 3 beats (last on 3rd), input 0 valid throughout -> gnt_idx=2 for 3 handshakes, then 0; ptr=3 after packet.
- Backpressure stability: ptr=0, only input 3 valid, rdy_m=0 for 5 cycles, input 1 asserts on cycle 2 -> gnt_idx stays 3, data_m unchanged; rdy_m=1 -> input 3 beat accepted, then input 1.
- Wrap and gap: locked input 1 drops vld_s for 2 cycles mid-packet while input 2 valid -> vld_m=0, rdy_s=0 for those cycles, packet resumes on input 1.
- Mid-packet reset: rst pulse during a LOCK on input 3 -> mode ARB, ptr=0; next grant goes to lowest valid index.
